// File: rtl/armleocpu_ptw_pkg.sv
// Shared definitions for the Sv32 page table walker: PTE bit positions,
// walker states and small PTE classification helpers.
package armleocpu_ptw_pkg;

   localparam int PTE_V = 0;
   localparam int PTE_R = 1;
   localparam int PTE_W = 2;
   localparam int PTE_X = 3;
   localparam int PTE_U = 4;
   localparam int PTE_G = 5;
   localparam int PTE_A = 6;
   localparam int PTE_D = 7;

   typedef enum logic [1:0] {
      STATE_IDLE = 2'd0,
      STATE_READ = 2'd1,
      STATE_STEP = 2'd2
   } ptw_state_t;

   // A PTE is unusable when it is not valid or encodes the reserved W-without-R combination
   function automatic logic pte_invalid(input logic [31:0] pte);
      return !pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W]);
   endfunction

   // Any readable or executable PTE terminates the walk as a leaf
   function automatic logic pte_leaf(input logic [31:0] pte);
      return pte[PTE_R] || pte[PTE_X];
   endfunction

endpackage

// File: rtl/armleocpu_ptw.sv
// Sv32 two-level hardware page table walker. Walks the table through a
// single-outstanding memory read port and returns PPN plus access tag.
// Only structural PTE checks are done here; permissions live downstream.
module armleocpu_ptw
   import armleocpu_ptw_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,

   input  logic        resolve_request,
   output logic        resolve_ack,
   input  logic [19:0] resolve_virtual_address,
   input  logic [21:0] csr_satp_ppn,

   output logic        resolve_done,
   output logic        resolve_pagefault,
   output logic        resolve_accessfault,
   output logic [21:0] resolve_physical_address,
   output logic [7:0]  resolve_accesstag,

   output logic        mem_read_req,
   output logic [33:0] mem_address,
   input  logic        mem_read_done,
   input  logic        mem_read_error,
   input  logic [31:0] mem_read_data
);

   ptw_state_t  state;
   ptw_state_t  state_next;

   logic [19:0] vpn;
   logic        level;

   logic        walk_accessfault;
   logic        walk_pagefault;
   logic        walk_success;
   logic        walk_descend;
   logic [21:0] leaf_ppn;

   logic [33:0] root_address;
   logic [33:0] next_address;

   // Address of the level-1 PTE (from the incoming request) and of the level-0 PTE (from the current PTE)
   assign root_address = {csr_satp_ppn, 12'b0} + {22'b0, resolve_virtual_address[19:10], 2'b00};
   assign next_address = {mem_read_data[31:10], 12'b0} + {22'b0, vpn[9:0], 2'b00};

   // Classify the PTE returned by memory into exactly one walk outcome, highest priority first
   always_comb begin
      walk_accessfault = 1'b0;
      walk_pagefault   = 1'b0;
      walk_success     = 1'b0;
      walk_descend     = 1'b0;
      leaf_ppn         = '0;
      if (mem_read_error) begin
         walk_accessfault = 1'b1;
      end else if (pte_invalid(mem_read_data)) begin
         walk_pagefault = 1'b1;
      end else if (pte_leaf(mem_read_data)) begin
         if (level) begin
            if (mem_read_data[19:10] != 10'd0) begin
               walk_pagefault = 1'b1;
            end else begin
               walk_success = 1'b1;
               leaf_ppn     = {mem_read_data[31:20], vpn[9:0]};
            end
         end else begin
            walk_success = 1'b1;
            leaf_ppn     = mem_read_data[31:10];
         end
      end else if (!level) begin
         walk_pagefault = 1'b1;
      end else begin
         walk_descend = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= STATE_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state selection: STEP always inserts one idle cycle before the second read
   always_comb begin
      state_next = state;
      case (state)
         STATE_IDLE: begin
            if (resolve_request) begin
               state_next = STATE_READ;
            end
         end
         STATE_READ: begin
            if (mem_read_done) begin
               state_next = walk_descend ? STATE_STEP : STATE_IDLE;
            end
         end
         STATE_STEP: begin
            state_next = STATE_READ;
         end
         default: begin
            state_next = STATE_IDLE;
         end
      endcase
   end

   // Registered outputs and walk context, all cleared by reset so the memory request drops immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resolve_ack              <= 1'b0;
         resolve_done             <= 1'b0;
         resolve_pagefault        <= 1'b0;
         resolve_accessfault      <= 1'b0;
         resolve_physical_address <= '0;
         resolve_accesstag        <= '0;
         mem_read_req             <= 1'b0;
         mem_address              <= '0;
         vpn                      <= '0;
         level                    <= 1'b0;
      end else begin
         resolve_ack  <= 1'b0;
         resolve_done <= 1'b0;
         case (state)
            STATE_IDLE: begin
               if (resolve_request) begin
                  resolve_ack              <= 1'b1;
                  vpn                      <= resolve_virtual_address;
                  level                    <= 1'b1;
                  mem_address              <= root_address;
                  mem_read_req             <= 1'b1;
                  resolve_pagefault        <= 1'b0;
                  resolve_accessfault      <= 1'b0;
                  resolve_physical_address <= '0;
                  resolve_accesstag        <= '0;
               end
            end
            STATE_READ: begin
               if (mem_read_done) begin
                  mem_read_req <= 1'b0;
                  if (walk_descend) begin
                     level       <= 1'b0;
                     mem_address <= next_address;
                  end else begin
                     resolve_done             <= 1'b1;
                     resolve_accessfault      <= walk_accessfault;
                     resolve_pagefault        <= walk_pagefault;
                     resolve_physical_address <= walk_success ? leaf_ppn : 22'd0;
                     resolve_accesstag        <= walk_success ? mem_read_data[7:0] : 8'd0;
                  end
               end
            end
            STATE_STEP: begin
               mem_read_req <= 1'b1;
            end
            default: begin
               mem_read_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_armleocpu_ptw.sv
// Directed self-checking bench for the Sv32 page table walker.
module tb_armleocpu_ptw;

   logic        clk;
   logic        rst_n;
   logic        resolve_request;
   logic        resolve_ack;
   logic [19:0] resolve_virtual_address;
   logic [21:0] csr_satp_ppn;
   logic        resolve_done;
   logic        resolve_pagefault;
   logic        resolve_accessfault;
   logic [21:0] resolve_physical_address;
   logic [7:0]  resolve_accesstag;
   logic        mem_read_req;
   logic [33:0] mem_address;
   logic        mem_read_done;
   logic        mem_read_error;
   logic [31:0] mem_read_data;

   int total;
   int bad;
   int cycle_count;

   armleocpu_ptw dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .resolve_request          (resolve_request),
      .resolve_ack              (resolve_ack),
      .resolve_virtual_address  (resolve_virtual_address),
      .csr_satp_ppn             (csr_satp_ppn),
      .resolve_done             (resolve_done),
      .resolve_pagefault        (resolve_pagefault),
      .resolve_accessfault      (resolve_accessfault),
      .resolve_physical_address (resolve_physical_address),
      .resolve_accesstag        (resolve_accesstag),
      .mem_read_req             (mem_read_req),
      .mem_address              (mem_address),
      .mem_read_done            (mem_read_done),
      .mem_read_error           (mem_read_error),
      .mem_read_data            (mem_read_data)
   );

   // Free-running clock and edge counter used for latency measurements
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle_count <= cycle_count + 1;

   // Raise a request at a falling edge and wait (bounded) for the ack
   task automatic start_walk(input logic [19:0] va, input logic [21:0] satp, output logic ok, output int ack_cycle);
      ok = 1'b0;
      ack_cycle = 0;
      resolve_virtual_address = va;
      csr_satp_ppn = satp;
      resolve_request = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (resolve_ack) begin
            ok = 1'b1;
            ack_cycle = cycle_count;
            break;
         end
      end
      resolve_request = 1'b0;
   endtask

   // Memory model: wait for a request, then answer after 1+stall cycles with one done pulse
   task automatic mem_respond(input int stall, input logic [31:0] data, input logic err,
                              output logic [33:0] addr, output int gap, output logic ok);
      ok = 1'b0;
      gap = 0;
      addr = '0;
      for (int i = 0; i < 20; i++) begin
         if (mem_read_req) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         gap++;
      end
      if (ok) begin
         addr = mem_address;
         repeat (1 + stall) @(negedge clk);
         mem_read_done = 1'b1;
         mem_read_data = data;
         mem_read_error = err;
         @(negedge clk);
         mem_read_done = 1'b0;
         mem_read_error = 1'b0;
      end
   endtask

   // Wait (bounded) for resolve_done at a falling edge
   task automatic wait_done(output logic ok, output int done_cycle);
      ok = 1'b0;
      done_cycle = 0;
      for (int i = 0; i < 20; i++) begin
         if (resolve_done) begin
            ok = 1'b1;
            done_cycle = cycle_count;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({resolve_ack, resolve_done, resolve_pagefault, resolve_accessfault, mem_read_req} !== 5'b0) begin
         bad++;
         $display("[TB] FAIL reset_flags got=%b want=00000",
                  {resolve_ack, resolve_done, resolve_pagefault, resolve_accessfault, mem_read_req});
      end
      total++;
      if ({mem_address, resolve_physical_address, resolve_accesstag} !== 64'd0) begin
         bad++;
         $display("[TB] FAIL reset_fields addr=%h pa=%h tag=%h want all 0",
                  mem_address, resolve_physical_address, resolve_accesstag);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_two_level();
      logic ok, ok1, ok2, okd;
      logic [33:0] a1, a2;
      int g1, g2, ca, cd;
      logic [21:0] pa_seen;
      start_walk(20'h12345, 22'h00001, ok, ca);
      mem_respond(0, 32'h0000_0801, 1'b0, a1, g1, ok1);
      mem_respond(0, 32'h2AF3_78CF, 1'b0, a2, g2, ok2);
      wait_done(okd, cd);
      total++;
      if (!(ok && ok1 && ok2 && okd)) begin
         bad++;
         $display("[TB] FAIL two_level_handshake ack=%b rd1=%b rd2=%b done=%b want 1111", ok, ok1, ok2, okd);
      end
      total++;
      if (a1 !== 34'h1120) begin bad++; $display("[TB] FAIL two_level_addr1 got=%h want=1120", a1); end
      total++;
      if (a2 !== 34'h2D14) begin bad++; $display("[TB] FAIL two_level_addr2 got=%h want=2d14", a2); end
      total++;
      if (g2 !== 1) begin bad++; $display("[TB] FAIL two_level_gap got=%0d want=1", g2); end
      total++;
      if (cd - ca !== 5) begin bad++; $display("[TB] FAIL two_level_latency got=%0d want=5", cd - ca); end
      total++;
      if ({resolve_pagefault, resolve_accessfault, resolve_physical_address, resolve_accesstag} !== {2'b00, 22'hABCDE, 8'hCF}) begin
         bad++;
         $display("[TB] FAIL two_level_result pf=%b af=%b pa=%h tag=%h want pf=0 af=0 pa=abcde tag=cf",
                  resolve_pagefault, resolve_accessfault, resolve_physical_address, resolve_accesstag);
      end
      total++;
      if (mem_read_req !== 1'b0) begin bad++; $display("[TB] FAIL two_level_req_at_done got=%b want=0", mem_read_req); end
      pa_seen = 22'hABCDE;
      @(negedge clk);
      total++;
      if (resolve_done !== 1'b0) begin bad++; $display("[TB] FAIL two_level_done_pulse got=%b want=0", resolve_done); end
      repeat (2) @(negedge clk);
      total++;
      if (resolve_physical_address !== pa_seen) begin
         bad++;
         $display("[TB] FAIL two_level_hold got=%h want=%h", resolve_physical_address, pa_seen);
      end
   endtask

   task automatic test_megapage();
      logic ok, ok1, okd;
      logic [33:0] a1;
      int g1, ca, cd;
      logic extra_req;
      start_walk(20'h12345, 22'h00003, ok, ca);
      mem_respond(0, 32'h0010_00CB, 1'b0, a1, g1, ok1);
      wait_done(okd, cd);
      total++;
      if (!(ok && ok1 && okd)) begin
         bad++;
         $display("[TB] FAIL mega_handshake ack=%b rd=%b done=%b want 111", ok, ok1, okd);
      end
      total++;
      if (a1 !== 34'h3120) begin bad++; $display("[TB] FAIL mega_addr got=%h want=3120", a1); end
      total++;
      if (cd - ca !== 2) begin bad++; $display("[TB] FAIL mega_latency got=%0d want=2", cd - ca); end
      total++;
      if ({resolve_pagefault, resolve_accessfault, resolve_physical_address, resolve_accesstag} !== {2'b00, 22'h00745, 8'hCB}) begin
         bad++;
         $display("[TB] FAIL mega_result pf=%b af=%b pa=%h tag=%h want pf=0 af=0 pa=00745 tag=cb",
                  resolve_pagefault, resolve_accessfault, resolve_physical_address, resolve_accesstag);
      end
      extra_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         extra_req = extra_req | mem_read_req;
         @(negedge clk);
      end
      total++;
      if (extra_req !== 1'b0) begin bad++; $display("[TB] FAIL mega_no_second_read got=%b want=0", extra_req); end
   endtask

   task automatic test_level1_faults();
      logic [31:0] ptes [2];
      logic ok, ok1, okd;
      logic [33:0] a1;
      int g1, ca, cd;
      ptes[0] = 32'h0010_04CB;
      ptes[1] = 32'h0000_0005;
      for (int t = 0; t < 2; t++) begin
         start_walk(20'h12345, 22'h00001, ok, ca);
         mem_respond(0, ptes[t], 1'b0, a1, g1, ok1);
         wait_done(okd, cd);
         total++;
         if ({ok, ok1, okd, resolve_pagefault, resolve_accessfault, resolve_physical_address, resolve_accesstag} !==
             {3'b111, 2'b10, 22'd0, 8'd0}) begin
            bad++;
            $display("[TB] FAIL l1_fault pte=%h hs=%b%b%b pf=%b af=%b pa=%h tag=%h want hs=111 pf=1 af=0 pa=0 tag=0",
                     ptes[t], ok, ok1, okd, resolve_pagefault, resolve_accessfault,
                     resolve_physical_address, resolve_accesstag);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_level0_faults();
      logic [31:0] ptes [2];
      logic ok, ok1, ok2, okd;
      logic [33:0] a1, a2;
      int g1, g2, ca, cd;
      ptes[0] = 32'h0000_0C01;
      ptes[1] = 32'h2AF3_78CE;
      for (int t = 0; t < 2; t++) begin
         start_walk(20'h12345, 22'h00001, ok, ca);
         mem_respond(0, 32'h0000_0801, 1'b0, a1, g1, ok1);
         mem_respond(0, ptes[t], 1'b0, a2, g2, ok2);
         wait_done(okd, cd);
         total++;
         if ({ok, ok1, ok2, okd, resolve_pagefault, resolve_accessfault, resolve_physical_address, resolve_accesstag} !==
             {4'b1111, 2'b10, 22'd0, 8'd0}) begin
            bad++;
            $display("[TB] FAIL l0_fault pte=%h hs=%b%b%b%b pf=%b af=%b pa=%h tag=%h want hs=1111 pf=1 af=0 pa=0 tag=0",
                     ptes[t], ok, ok1, ok2, okd, resolve_pagefault, resolve_accessfault,
                     resolve_physical_address, resolve_accesstag);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_access_error();
      logic ok, ok1, ok2, okd;
      logic [33:0] a1, a2;
      int g1, g2, ca, cd;
      start_walk(20'h12345, 22'h00001, ok, ca);
      mem_respond(0, 32'h0000_0801, 1'b0, a1, g1, ok1);
      mem_respond(0, 32'h2AF3_78CF, 1'b1, a2, g2, ok2);
      wait_done(okd, cd);
      total++;
      if ({ok, ok1, ok2, okd, resolve_pagefault, resolve_accessfault, resolve_physical_address, resolve_accesstag} !==
          {4'b1111, 2'b01, 22'd0, 8'd0}) begin
         bad++;
         $display("[TB] FAIL access_error hs=%b%b%b%b pf=%b af=%b pa=%h tag=%h want hs=1111 pf=0 af=1 pa=0 tag=0",
                  ok, ok1, ok2, okd, resolve_pagefault, resolve_accessfault,
                  resolve_physical_address, resolve_accesstag);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic ok, ok1, okd;
      logic [33:0] a1;
      int g1, cd;
      logic early_ack;
      resolve_virtual_address = 20'h12345;
      csr_satp_ppn = 22'h00001;
      resolve_request = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (resolve_ack) begin ok = 1'b1; break; end
      end
      early_ack = 1'b0;
      ok1 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (mem_read_req) begin ok1 = 1'b1; break; end
         @(negedge clk);
      end
      @(negedge clk);
      early_ack = early_ack | resolve_ack;
      mem_read_done = 1'b1;
      mem_read_data = 32'h0010_00CB;
      mem_read_error = 1'b0;
      @(negedge clk);
      mem_read_done = 1'b0;
      okd = resolve_done;
      early_ack = early_ack | resolve_ack;
      total++;
      if ({ok, ok1, okd, early_ack} !== 4'b1110) begin
         bad++;
         $display("[TB] FAIL held_request ack=%b rd=%b done=%b early_ack=%b want 1110", ok, ok1, okd, early_ack);
      end
      @(negedge clk);
      total++;
      if (resolve_ack !== 1'b1) begin bad++; $display("[TB] FAIL accept_after_done got=%b want=1", resolve_ack); end
      resolve_request = 1'b0;
      mem_respond(0, 32'h0010_00CB, 1'b0, a1, g1, ok1);
      wait_done(okd, cd);
      total++;
      if ({ok1, okd, resolve_physical_address} !== {2'b11, 22'h00745}) begin
         bad++;
         $display("[TB] FAIL second_walk rd=%b done=%b pa=%h want rd=1 done=1 pa=00745", ok1, okd, resolve_physical_address);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midwalk();
      logic ok, okd;
      logic [33:0] a1;
      int g1, ca, cd;
      logic spurious;
      start_walk(20'h12345, 22'h00001, ok, ca);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({ok, resolve_ack, resolve_done, mem_read_req, mem_address} !== {1'b1, 3'b000, 34'd0}) begin
         bad++;
         $display("[TB] FAIL reset_midwalk ack_seen=%b ack=%b done=%b req=%b addr=%h want 1 0 0 0 0",
                  ok, resolve_ack, resolve_done, mem_read_req, mem_address);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mem_read_done = 1'b1;
      mem_read_data = 32'h0010_00CB;
      @(negedge clk);
      mem_read_done = 1'b0;
      spurious = 1'b0;
      for (int i = 0; i < 4; i++) begin
         spurious = spurious | resolve_done | resolve_ack | mem_read_req;
         @(negedge clk);
      end
      total++;
      if (spurious !== 1'b0) begin bad++; $display("[TB] FAIL stale_done_ignored got=%b want=0", spurious); end
      start_walk(20'h12345, 22'h00001, ok, ca);
      mem_respond(0, 32'h0010_00CB, 1'b0, a1, g1, okd);
      total++;
      if ({ok, okd, a1} !== {2'b11, 34'h1120}) begin
         bad++;
         $display("[TB] FAIL walk_after_reset ack=%b rd=%b addr=%h want 1 1 1120", ok, okd, a1);
      end
      wait_done(okd, cd);
      @(negedge clk);
   endtask

   // Run every scenario in order, then report
   initial begin
      total = 0;
      bad = 0;
      cycle_count = 0;
      rst_n = 1'b0;
      resolve_request = 1'b0;
      resolve_virtual_address = '0;
      csr_satp_ppn = '0;
      mem_read_done = 1'b0;
      mem_read_error = 1'b0;
      mem_read_data = '0;
      @(negedge clk);
      test_reset();
      test_two_level();
      test_megapage();
      test_level1_faults();
      test_level0_faults();
      test_access_error();
      test_back_to_back();
      test_reset_midwalk();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
